// File: rtl/ball_pkg.sv
// Shared definitions for the ping-pong LED-matrix scan driver: default
// matrix geometry, the per-row scan state and the blanked row-select value.
package ball_pkg;

  localparam int BALL_COLS = 8;
  localparam int BALL_ROWS = 8;
  localparam int BALL_XW   = $clog2(BALL_COLS);
  localparam int BALL_YW   = $clog2(BALL_ROWS);

  // All row selects released (rows are active-low); sliced to ROWS bits.
  localparam logic [63:0] ROW_OFF = '1;

  // Each row period starts blanked to hide ghosting, then drives the row.
  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/matrix_row_pattern.sv
// Combinational column pattern for one matrix row: ball pixel plus left
// (column 0) and right (column COLS-1) paddles, OR-ed together.
// Paddles clip at the bottom row; the ball is hidden while blink_on is low.
module matrix_row_pattern #(
  parameter int COLS       = 8,
  parameter int ROWS       = 8,
  parameter int PADDLE_LEN = 3
) (
  input  logic [$clog2(ROWS)-1:0] row,
  input  logic [$clog2(COLS)-1:0] ball_x,
  input  logic [$clog2(ROWS)-1:0] ball_y,
  input  logic [$clog2(ROWS)-1:0] paddle_l,
  input  logic [$clog2(ROWS)-1:0] paddle_r,
  input  logic                    blink_on,
  output logic [COLS-1:0]         pattern
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam logic [YW:0] LEN = (YW+1)'(PADDLE_LEN);

  // One extra bit on the bottom edge keeps top+LEN from wrapping back to row 0.
  function automatic logic in_paddle(input logic [YW-1:0] top,
                                     input logic [YW-1:0] r);
    logic [YW:0] top_w;
    logic [YW:0] r_w;
    top_w = {1'b0, top};
    r_w   = {1'b0, r};
    return (top_w <= r_w) && (r_w < top_w + LEN);
  endfunction

  // Build the row pattern from ball and paddle positions.
  always_comb begin
    // NOTE: default assignment first so every path drives pattern; no latch.
    pattern = '0;
    if (blink_on && (ball_y == row)) begin
      for (int c = 0; c < COLS; c++) begin
        // A column code >= COLS matches no column, so it is simply not drawn.
        if (ball_x == XW'(c)) pattern[c] = 1'b1;
      end
    end
    if (in_paddle(paddle_l, row)) pattern[0]      = 1'b1;
    if (in_paddle(paddle_r, row)) pattern[COLS-1] = 1'b1;
  end

endmodule

// File: rtl/ball_matrix_scan.sv
// Time-multiplexed LED-matrix scan driver for the ping-pong display.
// Scans one row per SCAN_DIV clocks, blanking the first BLANK_CYC clocks of
// each row. Positions are captured into pending registers and committed to
// the active set only at the frame boundary, so a frame never tears.
// Optional ball blinking is enabled by defining BALL_BLINK_EN.
module ball_matrix_scan
  import ball_pkg::*;
#(
  parameter int COLS       = BALL_COLS,
  parameter int ROWS       = BALL_ROWS,
  parameter int XW         = BALL_XW,
  parameter int YW         = BALL_YW,
  parameter int PADDLE_LEN = 3,
  parameter int SCAN_DIV   = 16,
  parameter int BLANK_CYC  = 2
`ifdef BALL_BLINK_EN
  ,
  parameter int BLINK_DIV  = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XW-1:0]   X,
  input  logic [YW-1:0]   Y,
  input  logic [YW-1:0]   paddle_l,
  input  logic [YW-1:0]   paddle_r,
  input  logic            pos_valid,
  output logic [COLS-1:0] Sx,
  output logic [ROWS-1:0] Sy,
  output logic            frame_start
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0]   div_cnt;
  logic [YW-1:0]   row_idx;
  logic            div_last;
  logic            commit;
  scan_state_t     state_q;
  scan_state_t     state_d;

  logic [XW-1:0]   pend_x;
  logic [YW-1:0]   pend_y;
  logic [YW-1:0]   pend_pl;
  logic [YW-1:0]   pend_pr;
  logic [XW-1:0]   act_x;
  logic [YW-1:0]   act_y;
  logic [YW-1:0]   act_pl;
  logic [YW-1:0]   act_pr;

  logic            blink_on;
  logic [COLS-1:0] row_pat;
  logic [COLS-1:0] sx_d;
  logic [ROWS-1:0] sy_d;
  logic            fs_d;

  assign div_last = (div_cnt == DW'(SCAN_DIV - 1));
  assign commit   = div_last && (row_idx == YW'(ROWS - 1));

  // Row-period divider and row counter; row advances on the last divider tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      div_cnt <= '0;
      row_idx <= '0;
    end else if (div_last) begin
      div_cnt <= '0;
      row_idx <= (row_idx == YW'(ROWS - 1)) ? '0 : row_idx + YW'(1);
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BLANK;
    else     state_q <= state_d;
  end

  // Next scan state plus next-cycle output values derived from counter state.
  always_comb begin
    state_d = state_q;
    sx_d    = '0;
    sy_d    = ROW_OFF[ROWS-1:0];
    fs_d    = (div_cnt == '0) && (row_idx == '0);
    case (state_q)
      BLANK: begin
        if (div_cnt == DW'(BLANK_CYC - 1)) state_d = DRIVE;
      end
      DRIVE: begin
        sx_d = row_pat;
        sy_d = ~(ROWS'(1) << row_idx);
        if (div_last) state_d = BLANK;
      end
      default: state_d = BLANK;
    endcase
  end

  // Registered matrix outputs; reset forces the display dark immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sx          <= '0;
      Sy          <= ROW_OFF[ROWS-1:0];
      frame_start <= 1'b0;
    end else begin
      Sx          <= sx_d;
      Sy          <= sy_d;
      frame_start <= fs_d;
    end
  end

  // Shadow registers: capture any time, commit only at the frame boundary.
  // A capture landing on the commit cycle goes straight to the active set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_x  <= '0;
      pend_y  <= '0;
      pend_pl <= '0;
      pend_pr <= '0;
      act_x   <= '0;
      act_y   <= '0;
      act_pl  <= '0;
      act_pr  <= '0;
    end else begin
      if (pos_valid) begin
        pend_x  <= X;
        pend_y  <= Y;
        pend_pl <= paddle_l;
        pend_pr <= paddle_r;
      end
      if (commit) begin
        act_x  <= pos_valid ? X        : pend_x;
        act_y  <= pos_valid ? Y        : pend_y;
        act_pl <= pos_valid ? paddle_l : pend_pl;
        act_pr <= pos_valid ? paddle_r : pend_pr;
      end
    end
  end

`ifdef BALL_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [FW-1:0] frame_cnt;

  // Frame counter toggles ball visibility every BLINK_DIV frames, at commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (commit) begin
      if (frame_cnt == FW'(BLINK_DIV - 1)) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end
`else
  assign blink_on = 1'b1;
`endif

  matrix_row_pattern #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .PADDLE_LEN (PADDLE_LEN)
  ) u_pattern (
    .row      (row_idx),
    .ball_x   (act_x),
    .ball_y   (act_y),
    .paddle_l (act_pl),
    .paddle_r (act_pr),
    .blink_on (blink_on),
    .pattern  (row_pat)
  );

endmodule

// File: tb/tb_ball_matrix_scan.sv
// Self-checking bench for ball_matrix_scan (8x8, PADDLE_LEN=3, SCAN_DIV=16,
// BLANK_CYC=2). Whole frames are captured on the falling edge, then compared
// against a table of hand-computed per-row paddle and ball patterns.
module tb_ball_matrix_scan;

  localparam int COLS       = 8;
  localparam int ROWS       = 8;
  localparam int PADDLE_LEN = 3;
  localparam int SCAN_DIV   = 16;
  localparam int BLANK_CYC  = 2;
  localparam int FRAME      = ROWS * SCAN_DIV;
`ifdef BALL_BLINK_EN
  localparam int BLINK_DIV  = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] x = '0;
  logic [2:0] y = '0;
  logic [2:0] paddle_l = '0;
  logic [2:0] paddle_r = '0;
  logic       pos_valid = 1'b0;
  logic [7:0] sx;
  logic [7:0] sy;
  logic       frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ball_matrix_scan #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .XW         (3),
    .YW         (3),
    .PADDLE_LEN (PADDLE_LEN),
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_CYC  (BLANK_CYC)
`ifdef BALL_BLINK_EN
    ,
    .BLINK_DIV  (BLINK_DIV)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .X           (x),
    .Y           (y),
    .paddle_l    (paddle_l),
    .paddle_r    (paddle_r),
    .pos_valid   (pos_valid),
    .Sx          (sx),
    .Sy          (sy),
    .frame_start (frame_start)
  );

  // Scenario record: positions to load and the expected per-row patterns.
  typedef struct {
    logic [2:0]      x;
    logic [2:0]      y;
    logic [2:0]      pl;
    logic [2:0]      pr;
    logic [7:0][7:0] pad;
    logic [7:0][7:0] ball;
  } scn_t;

  scn_t scn [6];

  logic [7:0] cap_sx [FRAME];
  logic [7:0] cap_sy [FRAME];
  logic       cap_fs [FRAME];
  int         waited;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Ball visibility for frame f counted from reset release.
  function automatic logic ball_vis(input int f);
`ifdef BALL_BLINK_EN
    return ((f / BLINK_DIV) % 2) == 0;
`else
    return f >= 0;
`endif
  endfunction

  task automatic set_scn(input int s, input logic [2:0] sxp, input logic [2:0] syp,
                         input logic [2:0] spl, input logic [2:0] spr);
    scn[s].x    = sxp;
    scn[s].y    = syp;
    scn[s].pl   = spl;
    scn[s].pr   = spr;
    scn[s].pad  = '0;
    scn[s].ball = '0;
  endtask

  // Waits (bounded) for frame_start, records one frame of outputs, and
  // optionally pulses pos_valid with scenario ld's positions at offset pv_k.
  task automatic capture_frame(input int pv_k, input int ld);
    waited = 0;
    while (frame_start !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("frame_start wait", {31'b0, frame_start}, 32'd1);
    for (int k = 0; k < FRAME; k++) begin
      cap_sx[k] = sx;
      cap_sy[k] = sy;
      cap_fs[k] = frame_start;
      if (k == pv_k) begin
        x         = scn[ld].x;
        y         = scn[ld].y;
        paddle_l  = scn[ld].pl;
        paddle_r  = scn[ld].pr;
        pos_valid = 1'b1;
      end else begin
        pos_valid = 1'b0;
      end
      @(negedge clk);
    end
    pos_valid = 1'b0;
  endtask

  // Compares a captured frame against scenario s for frame number f.
  task automatic check_frame(input int s, input int f);
    int         fs_cnt;
    int         k;
    logic [7:0] exp_sx;
    logic [7:0] exp_sy;
    logic [7:0] one;
    fs_cnt = 0;
    one    = 8'h01;
    for (int i = 0; i < FRAME; i++) if (cap_fs[i] === 1'b1) fs_cnt++;
    check($sformatf("f%0d frame_start at row0", f), {31'b0, cap_fs[0]}, 32'd1);
    check($sformatf("f%0d frame_start count", f), fs_cnt, 32'd1);
    for (int r = 0; r < ROWS; r++) begin
      k      = r * SCAN_DIV;
      exp_sx = scn[s].pad[r] | (ball_vis(f) ? scn[s].ball[r] : 8'h00);
      exp_sy = ~(one << r);
      check($sformatf("f%0d r%0d blank Sx", f, r), cap_sx[k+BLANK_CYC-1], 32'h00);
      check($sformatf("f%0d r%0d blank Sy", f, r), cap_sy[k+BLANK_CYC-1], 32'hFF);
      check($sformatf("f%0d r%0d first drive Sx", f, r), cap_sx[k+BLANK_CYC], exp_sx);
      check($sformatf("f%0d r%0d first drive Sy", f, r), cap_sy[k+BLANK_CYC], exp_sy);
      check($sformatf("f%0d r%0d last drive Sx", f, r), cap_sx[k+SCAN_DIV-1], exp_sx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 0: reset contents -- ball at (0,0), both paddles at row 0.
    set_scn(0, 3'd0, 3'd0, 3'd0, 3'd0);
    scn[0].pad[0] = 8'h81; scn[0].pad[1] = 8'h81; scn[0].pad[2] = 8'h81;
    scn[0].ball[0] = 8'h01;
    // 1: ball (3,5), paddles at 0.
    set_scn(1, 3'd3, 3'd5, 3'd0, 3'd0);
    scn[1].pad[0] = 8'h81; scn[1].pad[1] = 8'h81; scn[1].pad[2] = 8'h81;
    scn[1].ball[5] = 8'h08;
    // 2: ball (7,0), left paddle rows 4..6, right paddle rows 3..5.
    set_scn(2, 3'd7, 3'd0, 3'd4, 3'd3);
    scn[2].pad[3] = 8'h80; scn[2].pad[4] = 8'h81;
    scn[2].pad[5] = 8'h81; scn[2].pad[6] = 8'h01;
    scn[2].ball[0] = 8'h80;
    // 3: ball (2,3), left paddle rows 5..7 exactly, right paddle clipped at 6..7.
    set_scn(3, 3'd2, 3'd3, 3'd5, 3'd6);
    scn[3].pad[5] = 8'h01; scn[3].pad[6] = 8'h81; scn[3].pad[7] = 8'h81;
    scn[3].ball[3] = 8'h04;
    // 4: ball (1,1), paddles at 0 -- loaded exactly on the commit cycle.
    set_scn(4, 3'd1, 3'd1, 3'd0, 3'd0);
    scn[4].pad[0] = 8'h81; scn[4].pad[1] = 8'h81; scn[4].pad[2] = 8'h81;
    scn[4].ball[1] = 8'h02;
    // 5: ball (4,4), paddles at 0 -- used for the blink sequence.
    set_scn(5, 3'd4, 3'd4, 3'd0, 3'd0);
    scn[5].pad[0] = 8'h81; scn[5].pad[1] = 8'h81; scn[5].pad[2] = 8'h81;
    scn[5].ball[4] = 8'h10;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset Sx", sx, 32'h00);
    check("reset Sy", sy, 32'hFF);
    check("reset frame_start", {31'b0, frame_start}, 32'd0);

    // Release: scan restarts at row 0; load scenario 1 early in frame 0.
    rst = 1'b0;
    capture_frame(1, 1);
    check("restart latency", waited, 32'd1);
    check_frame(0, 0);

    // Frame 1 shows scenario 1; mid-frame load of scenario 2 must not leak in.
    capture_frame(40, 2);
    check("frame period f1", waited, 32'd0);
    check_frame(1, 1);

    // Frame 2 shows scenario 2; load scenario 3 mid-frame.
    capture_frame(40, 3);
    check("frame period f2", waited, 32'd0);
    check_frame(2, 2);

    // Frame 3 shows clipped paddles; load scenario 4 on the commit cycle.
    capture_frame(FRAME - 2, 4);
    check_frame(3, 3);

    // Frame 4 shows the bypassed values; frame 5 shows them again from pending.
    capture_frame(-1, 0);
    check_frame(4, 4);
    capture_frame(-1, 0);
    check_frame(4, 5);

    // Asynchronous reset in the middle of row 1's drive window.
    repeat (SCAN_DIV + 8) @(negedge clk);
    check("pre-reset row1 Sy", sy, 32'hFD);
    check("pre-reset row1 Sx", sx, ball_vis(6) ? 32'h83 : 32'h81);
    #2 rst = 1'b1;
    #1;
    check("async reset Sx", sx, 32'h00);
    check("async reset Sy", sy, 32'hFF);
    check("async reset frame_start", {31'b0, frame_start}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Post-reset frame uses cleared registers; then the blink sequence.
    capture_frame(20, 5);
    check("restart latency after reset", waited, 32'd1);
    check_frame(0, 0);
    for (int f = 1; f <= 4; f++) begin
      capture_frame(-1, 0);
      check_frame(5, f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_matrix_scan.md
Name: ball_matrix_scan

Overview:
Time-multiplexed LED-matrix scan driver for the ping-pong display. It replaces the static single-pixel ball decoder with a refreshed frame containing the ball plus left and right paddles. The frame is scanned one row at a time, with a blanking interval per row and tear-free position updates at frame boundaries. It sits between the game-logic position registers and the matrix row/column pins.

Parameters:
COLS, 8, matrix columns (Sx width), >=2
ROWS, 8, matrix rows (Sy width), >=2
XW, 3, ball X width, $clog2(COLS)
YW, 3, ball Y / paddle-top width, $clog2(ROWS)
PADDLE_LEN, 3, paddle height in rows, 1..ROWS
SCAN_DIV, 16, clocks per row period, >BLANK_CYC
BLANK_CYC, 2, blanked clocks at start of each row period, >=1
BLINK_DIV, 32, frames per blink half-period (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  reset
X  in  XW  ball column
Y  in  YW  ball row
paddle_l  in  YW  left paddle top row (column 0)
paddle_r  in  YW  right paddle top row (column COLS-1)
pos_valid  in  1  sample X/Y/paddles into pending registers this cycle
Sx  out  COLS  column drive, active-high, pattern of current row
Sy  out  ROWS  row select, active-low, one-cold during drive
frame_start  out  1  one-cycle pulse at start of row 0 period

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values: Sx=0, Sy=all ones, frame_start=0, div_cnt=0, row_idx=0, state=BLANK, pending and active X/Y/paddle registers=0.
- div_cnt counts 0..SCAN_DIV-1 and wraps. row_idx increments when div_cnt==SCAN_DIV-1, wrapping ROWS-1 -> 0.
- FSM per row period:
  - BLANK for div_cnt<BLANK_CYC.
  - DRIVE for div_cnt>=BLANK_CYC.
  - BLANK -> DRIVE at div_cnt==BLANK_CYC-1.
  - DRIVE -> BLANK at div_cnt==SCAN_DIV-1.
- Outputs are registered, with one cycle of latency from counter state.
  - BLANK: Sx=0, Sy=all ones.
  - DRIVE: Sy=~(1<<row_idx), Sx=pattern(row_idx).
- pattern(r), built from active registers:
  - bit X set if Y==r and X<COLS; an out-of-range ball is not drawn.
  - bit 0 set if paddle_l<=r<paddle_l+PADDLE_LEN.
  - bit COLS-1 set if the same test holds for paddle_r.
  - Paddles clip at row ROWS-1; no wrap. The sum is computed at YW+1 bits.
  - Overlaps are OR-ed.
- frame_start=1 for exactly the one cycle in which outputs reflect row_idx=0, div_cnt=0.
- pos_valid=1 loads X, Y, paddle_l, paddle_r into pending. It is never visible mid-frame.
- Commit pending->active at div_cnt==SCAN_DIV-1 && row_idx==ROWS-1. The next frame uses the new values.
- pos_valid coincident with commit bypasses: active takes the incoming port values, and pending is also loaded.
- Reset asserted mid-frame: outputs blank immediately (asynchronous). After release the scan restarts at row 0 in BLANK.

Optional Feature:
Macro BALL_BLINK_EN.
- Defined: a frame counter toggles blink_on every BLINK_DIV frames (reset: blink_on=1). While blink_on=0 the ball bit is suppressed in every row; paddles stay unaffected. Toggling occurs at commit time, so a whole frame is consistent.
- Undefined: no counter, and the ball is always drawn.

Decomposition:
- Shared package ball_pkg: default COLS/ROWS/XW/YW, the scan_state_t enum {BLANK, DRIVE}, and a ROW_OFF constant (all ones).
- One sub-module, matrix_row_pattern: combinational pattern(r) from row index, ball position, paddles and blink_on, parameterised by COLS/ROWS/PADDLE_LEN.
- Counters, FSM, shadow registers and output registers stay in ball_matrix_scan.

Test Plan:
1. Reset, then release: Sx=0 and Sy=8'hFF for the first 2 cycles. frame_start pulses once every 8*16=128 cycles.
2. pos_valid with X=3, Y=5, paddles at 0, PADDLE_LEN=3, after one full frame:
   - row 5 drive shows Sy=8'hDF, Sx=8'h08.
   - rows 0..2 show Sx=8'h01 and 8'h80 OR-ed.
3. paddle_r=6: rows 6 and 7 show bit 7 set, row 0 does not (clipping, no wrap).
4. Mid-frame pos_valid X=7, Y=0: the current frame is unchanged. The next frame's row 0 shows Sx bit 7.
5. pos_valid exactly at commit with X=1, Y=1: the very next frame's row 1 shows Sx=8'h02 (bypass). Also assert rst mid-row and check immediate blank.
6. BALL_BLINK_EN with BLINK_DIV=2: the ball is visible for 2 frames and absent for 2 frames; paddles persist in all frames.
